// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
// Includes the D/E payload field layout used to pack and unpack the opaque bus.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_DATA_W_DEF = 32;
    localparam int PIPE_CNT_W_DEF  = 16;

    // D/E boundary payload, LSB first: S, WBA, PC8, EXT, RT, RS, INSTR
    localparam int DE_S_W     = 32;
    localparam int DE_WBA_W   = 5;
    localparam int DE_PC8_W   = 32;
    localparam int DE_EXT_W   = 32;
    localparam int DE_RT_W    = 32;
    localparam int DE_RS_W    = 32;
    localparam int DE_INSTR_W = 32;

    localparam int DE_S_LSB     = 0;
    localparam int DE_WBA_LSB   = DE_S_LSB + DE_S_W;
    localparam int DE_PC8_LSB   = DE_WBA_LSB + DE_WBA_W;
    localparam int DE_EXT_LSB   = DE_PC8_LSB + DE_PC8_W;
    localparam int DE_RT_LSB    = DE_EXT_LSB + DE_EXT_W;
    localparam int DE_RS_LSB    = DE_RT_LSB + DE_RT_W;
    localparam int DE_INSTR_LSB = DE_RS_LSB + DE_RS_W;
    localparam int DE_W         = DE_INSTR_LSB + DE_INSTR_W;

    typedef struct packed {
        logic [DE_INSTR_W-1:0] instr;
        logic [DE_RS_W-1:0]    rs;
        logic [DE_RT_W-1:0]    rt;
        logic [DE_EXT_W-1:0]   ext;
        logic [DE_PC8_W-1:0]   pc8;
        logic [DE_WBA_W-1:0]   wba;
        logic [DE_S_W-1:0]     s;
    } de_fields_t;

    function automatic logic [DE_W-1:0] de_pack(input de_fields_t f);
        return f;
    endfunction

    function automatic de_fields_t de_unpack(input logic [DE_W-1:0] bus);
        return bus;
    endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, hold, flush, bubble zeroing,
// saturating backpressure counter. Define PIPE_STAGE_REG_SKID_EN for a registered-ready skid buffer.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W         = PIPE_DATA_W_DEF,
    parameter bit ZERO_ON_BUBBLE = 1'b1,
    parameter int CNT_W          = PIPE_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              accept;
    logic              consume;
    logic [DATA_W-1:0] main_q, main_d;

    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready && !hold;
    assign out_data = main_q;

`ifdef PIPE_STAGE_REG_SKID_EN
    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              rdy_q, rdy_d;

    // Ready comes from a flop so out_ready never reaches in_ready combinationally.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = rdy_q && !hold;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        rdy_d   = rdy_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
            rdy_d   = 1'b1;
        end else if (!hold) begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                        if (ZERO_ON_BUBBLE) main_d = '0;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = '0;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
            rdy_d = (state_d != ST_TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
        end
    end
`else
    logic valid_q, valid_d;

    assign out_valid = valid_q;
    assign in_ready  = !hold && (out_ready || !valid_q);

    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
            valid_d = 1'b0;
            main_d  = '0;
        end else if (!hold) begin
            if (accept) begin
                valid_d = 1'b1;
                main_d  = in_data;
            end else if (consume) begin
                valid_d = 1'b0;
                if (ZERO_ON_BUBBLE) main_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            main_q  <= '0;
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
        end
    end
`endif

    pipe_sat_cnt #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc_i(out_valid && !out_ready && !hold),
        .clr_i(cnt_clr),
        .cnt_o(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized + directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [31:0] in_data = '0;

    logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [15:0] stall_a;
    logic [3:0]  stall_b;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .ZERO_ON_BUBBLE(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .cnt_clr(cnt_clr), .stall_cnt(stall_a)
    );

    pipe_stage_reg #(.DATA_W(32), .ZERO_ON_BUBBLE(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .cnt_clr(cnt_clr), .stall_cnt(stall_b)
    );

    // Reference model: FIFO of stored beats, last consumed value, two counters.
    logic [31:0] q[$];
    logic [31:0] last;
    int          cnt_a, cnt_b;
    bit          rdy_m;
    int          nchk = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
`ifdef PIPE_STAGE_REG_SKID_EN
        return rdy_m && !hold;
`else
        return !hold && (out_ready || q.size() == 0);
`endif
    endfunction

    task automatic check_out();
        bit          v;
        logic [31:0] da, db;
        v  = q.size() > 0;
        da = v ? q[0] : 32'd0;
        db = v ? q[0] : last;
        chk("out_valid_a", 64'(out_valid_a), 64'(v));
        chk("out_valid_b", 64'(out_valid_b), 64'(v));
        chk("out_data_a", 64'(out_data_a), 64'(da));
        chk("out_data_b", 64'(out_data_b), 64'(db));
        chk("stall_a", 64'(stall_a), 64'(cnt_a));
        chk("stall_b", 64'(stall_b), 64'(cnt_b));
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic tick();
        bit rdy, ov;
        #1;
        rdy = exp_ready();
        ov  = q.size() > 0;
        chk("in_ready_a", 64'(in_ready_a), 64'(rdy));
        chk("in_ready_b", 64'(in_ready_b), 64'(rdy));
        @(posedge clk);
        if (ov && !out_ready && !hold) begin
            if (cnt_a < 65535) cnt_a++;
            if (cnt_b < 15) cnt_b++;
        end
        if (cnt_clr) begin
            cnt_a = 0;
            cnt_b = 0;
        end
        if (flush) begin
            q.delete();
            last  = '0;
            rdy_m = 1'b1;
        end else if (!hold) begin
            if (ov && out_ready) last = q.pop_front();
            if (in_valid && rdy) q.push_back(in_data);
            rdy_m = q.size() < 2;
        end
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        last  = '0;
        cnt_a = 0;
        cnt_b = 0;
        rdy_m = 1'b0;
        #1;
        check_out();
        chk("rst_in_ready_a", 64'(in_ready_a), 64'(exp_ready()));
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        hold     = 1'b0;
        cnt_clr  = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        do_reset();

        // Reset mid-stream: asynchronous clear without waiting for an edge
        in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("pre_rst_data", 64'(out_data_a), 64'h0000_0000_DEAD_BEEF);
        #3;
        do_reset();

        // Throughput: 8 back-to-back beats
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            tick();
            chk("thru_data", 64'(out_data_a), 64'(i));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure: 0xA5 held for 5 stall cycles
        cnt_clr = 1'b1; in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b1;
        tick();
        cnt_clr = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'hB0 + 32'(i);
            tick();
        end
        chk("bp_data", 64'(out_data_a), 64'hA5);
        chk("bp_cnt", 64'(stall_a), 64'd5);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Flush beats hold; concurrent beat dropped
        in_valid = 1'b1; in_data = 32'h1234;
        tick();
        flush = 1'b1; hold = 1'b1; in_data = 32'h5678;
        tick();
        chk("flush_valid", 64'(out_valid_a), 64'd0);
        flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
        tick();

        // Hold keeps entry despite downstream accept
        in_valid = 1'b1; in_data = 32'h4242;
        tick();
        in_valid = 1'b0; hold = 1'b1;
        tick();
        tick();
        hold = 1'b0;
        tick();

        // Bubble: consumed without new input
        in_valid = 1'b1; in_data = 32'h77;
        tick();
        in_valid = 1'b0;
        tick();
        chk("bubble_a", 64'(out_data_a), 64'd0);
        chk("bubble_b", 64'(out_data_b), 64'h77);

        // Counter saturation, then clear concurrent with a stall cycle
        cnt_clr = 1'b1; in_valid = 1'b1; in_data = 32'h99;
        tick();
        cnt_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_b", 64'(stall_b), 64'd15);
        chk("sat_a", 64'(stall_a), 64'd20);
        cnt_clr = 1'b1;
        tick();
        chk("clr_b", 64'(stall_b), 64'd0);
        cnt_clr = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(99, 0) < 60);
            in_data   = $urandom();
            out_ready = ($urandom_range(99, 0) < 55);
            hold      = ($urandom_range(99, 0) < 12);
            flush     = ($urandom_range(99, 0) < 4);
            cnt_clr   = ($urandom_range(99, 0) < 3);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the successor to the fixed-field D/E/M/W stage registers. It carries one opaque payload bus, with the Instr/RS/RT/EXT/PC8/WBA/s fields concatenated by the instantiating stage. It adds a valid/ready handshake, stall (hold), flush and bubble zeroing, and keeps a saturating backpressure counter. It sits between any two pipeline stages in the CPU datapath; one instance per stage boundary.

Parameters:
DATA_W, 32, payload width in bits (D/E boundary: 32*6+5 = 197)
ZERO_ON_BUBBLE, 1, 1 = payload forced to 0 whenever out_valid is 0 (bubble = NOP, instr 0); 0 = payload holds its last value
CNT_W, 16, width of the stall counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all stored entries (branch/exception squash)
hold  in  1  freeze stage contents (load-use stall)
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  stored payload valid
out_ready  in  1  downstream accepts
out_data  out  DATA_W  stored payload
cnt_clr  in  1  synchronous clear of stall_cnt
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, stall_cnt=0, internal state EMPTY. When the skid buffer is compiled in, skid entry invalid and in_ready=0 while in reset. Deassertion takes effect at the next clk edge.
- Priority per edge: flush > hold > handshake.
- flush=1:
  - Next cycle out_valid=0, out_data=0, all entries invalid.
  - A concurrent in_valid beat is dropped.
  - stall_cnt is unaffected.
- hold=1 (flush=0):
  - All registers keep their values.
  - in_ready=0.
  - out_valid is unchanged; a downstream accept during hold is ignored, so the entry is not consumed.
- Base (no skid): single entry.
  - in_ready = !hold && (out_ready || !out_valid), combinational.
  - Accept when in_valid && in_ready. out_valid=1 and out_data=in_data one cycle later (latency 1).
  - If out_valid && out_ready and no accept, out_valid -> 0. Payload -> 0 if ZERO_ON_BUBBLE=1, else held.
  - Simultaneous consume and accept: the new beat replaces the old with no bubble (full throughput).
- stall_cnt:
  - +1 on each edge where out_valid && !out_ready && !hold.
  - Saturates at 2^CNT_W-1.
  - cnt_clr forces 0 and wins over a concurrent increment.
- Width rule: the payload is passed through untouched. No sign or zero extension.

Optional Feature:
Macro PIPE_STAGE_REG_SKID_EN.
- Defined: two-entry skid buffer (main + skid) so in_ready is a register output, breaking the ready combinational path.
  - in_ready = !skid_valid && !hold, registered.
  - FSM states EMPTY / ONE / TWO:
    - EMPTY + accept -> ONE.
    - ONE + accept + !consume -> TWO, beat goes to skid.
    - ONE + consume + !accept -> EMPTY.
    - ONE + accept + consume -> ONE.
    - TWO + consume -> ONE, skid moves to main, and in_ready rises the next cycle.
    - TWO never accepts.
  - Order is preserved.
  - flush -> EMPTY from any state.
  - Latency is still 1 cycle.
- Undefined: single-entry behaviour above. The skid register and FSM are absent.

Decomposition:
- Package pipe_pkg: state enum (ST_EMPTY, ST_ONE, ST_TWO), default DATA_W/CNT_W constants, and localparams for the D/E field widths and offsets used to pack and unpack the payload.
- Sub-module pipe_sat_cnt: saturating counter with inc/clr and param width, holding stall_cnt.

Test Plan:
- Reset mid-stream: in_valid=1, data 0xDEADBEEF accepted, then rst_n low between edges -> out_valid=0 and out_data=0 immediately, without waiting for an edge.
- Throughput: out_ready=1, 8 back-to-back beats 1..8 -> out_data 1..8 on consecutive cycles, 1-cycle latency, no bubbles.
- Backpressure: out_ready=0 for 5 cycles with a valid entry 0xA5 -> out_data stays 0xA5 and stall_cnt=5. With skid compiled in, one extra beat is accepted and then in_ready=0. After release, beats drain in order.
- Flush vs hold: flush=1 and hold=1 on the same edge with valid 0x1234 -> next cycle out_valid=0 and out_data=0. The concurrent input beat 0x5678 is not seen.
- Bubble: ZERO_ON_BUBBLE=1, entry 0x77 consumed with no new input -> out_valid=0 and out_data=0. With ZERO_ON_BUBBLE=0 -> out_data stays 0x77.
- Counter: CNT_W=4, stall for 20 cycles -> stall_cnt saturates at 15. cnt_clr asserted concurrently with a stall cycle -> 0.
